// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with interrupt arbitration and a trap/MRET handshake to the core.
// CSR reads are combinational; interrupt levels reach mip one cycle after the inputs.
module csr_irq_unit #(
  parameter int DW    = 32,
  parameter int ADDRW = 12,
  parameter int NLIRQ = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ADDRW-1:0] csr_addr_i,
  input  logic [1:0]       csr_op_i,
  input  logic [DW-1:0]    csr_wdata_i,
  output logic [DW-1:0]    csr_rdata_o,
  output logic             csr_illegal_o,
  input  logic             t_intr_i,
  input  logic             e_intr_i,
  input  logic             sw_intr_i,
  input  logic [NLIRQ-1:0] lirq_i,
  input  logic [DW-1:0]    pc_i,
  output logic             irq_req_o,
  input  logic             trap_ack_i,
  output logic [DW-1:0]    trap_pc_o,
  input  logic             mret_i,
  output logic [DW-1:0]    mret_pc_o
);

  localparam logic [ADDRW-1:0] A_MSTATUS  = ADDRW'('h300);
  localparam logic [ADDRW-1:0] A_MIE      = ADDRW'('h304);
  localparam logic [ADDRW-1:0] A_MTVEC    = ADDRW'('h305);
  localparam logic [ADDRW-1:0] A_MSCRATCH = ADDRW'('h340);
  localparam logic [ADDRW-1:0] A_MEPC     = ADDRW'('h341);
  localparam logic [ADDRW-1:0] A_MCAUSE   = ADDRW'('h342);
  localparam logic [ADDRW-1:0] A_MIP      = ADDRW'('h344);
  localparam logic [ADDRW-1:0] A_MCYCLE   = ADDRW'('hB00);
  localparam logic [ADDRW-1:0] A_MCYCLEH  = ADDRW'('hB80);

  // Implemented interrupt bits: MSI, MTI, MEI and the local lines from bit 16 up.
  localparam logic [DW-1:0] IRQ_MASK = DW'(((64'd1 << NLIRQ) - 64'd1) << 16) | DW'(32'h888);

  typedef enum logic {RUN, PEND} state_e;

  state_e        state_q, state_d;
  logic [4:0]    cause_q, cause_d, prio;
  logic          mstatus_mie_q, mstatus_mpie_q;
  logic [DW-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q, mcycle_q, mcycleh_q;
  logic [DW-1:0] mstatus_val, old_val, new_val, pend, mip_d, base;
  logic          legal, wr, take;

  assign mstatus_val = DW'({mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});
  assign pend        = mip_q & mie_q;
  assign take        = (state_q == PEND) && trap_ack_i;
  assign wr          = (csr_op_i != 2'b00) && legal;

  always_comb begin
    legal   = 1'b1;
    old_val = '0;
    case (csr_addr_i)
      A_MSTATUS:  old_val = mstatus_val;
      A_MIE:      old_val = mie_q;
      A_MTVEC:    old_val = mtvec_q;
      A_MSCRATCH: old_val = mscratch_q;
      A_MEPC:     old_val = mepc_q;
      A_MCAUSE:   old_val = mcause_q;
      A_MIP:      old_val = mip_q;
      A_MCYCLE:   old_val = mcycle_q;
      A_MCYCLEH:  old_val = mcycleh_q;
      default:    legal   = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      2'b01:   new_val = csr_wdata_i;
      2'b10:   new_val = old_val | csr_wdata_i;
      2'b11:   new_val = old_val & ~csr_wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign csr_rdata_o   = (rst_ni && wr) ? old_val : '0;
  assign csr_illegal_o = rst_ni && (csr_op_i != 2'b00) && !legal;

  always_comb begin
    mip_d              = '0;
    mip_d[3]           = sw_intr_i;
    mip_d[7]           = t_intr_i;
    mip_d[11]          = e_intr_i;
    mip_d[16 +: NLIRQ] = lirq_i;
  end

  // Later assignments win: lowest local index, then MTI, MSI, MEI on top.
  always_comb begin
    prio = '0;
    for (int k = NLIRQ - 1; k >= 0; k--) begin
      if (pend[16+k]) prio = 5'(16 + k);
    end
    if (pend[7])  prio = 5'd7;
    if (pend[3])  prio = 5'd3;
    if (pend[11]) prio = 5'd11;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      RUN: begin
        if (mstatus_mie_q && (pend != '0) && !mret_i) begin
          state_d = PEND;
          cause_d = prio;
        end
      end
      PEND: begin
        if (trap_ack_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mip_q          <= '0;
      mcycle_q       <= '0;
      mcycleh_q      <= '0;
    end else begin
      mip_q <= mip_d;
      if (wr && csr_addr_i == A_MIE)      mie_q      <= new_val & IRQ_MASK;
      if (wr && csr_addr_i == A_MTVEC)    mtvec_q    <= new_val & ~DW'(2);
      if (wr && csr_addr_i == A_MSCRATCH) mscratch_q <= new_val;
      if (take) begin
        // Trap entry owns mstatus/mepc/mcause this cycle; a racing write or MRET is lost.
        mepc_q         <= pc_i & ~DW'(3);
        mcause_q       <= {1'b1, {(DW-6){1'b0}}, cause_q};
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else begin
        if (wr && csr_addr_i == A_MEPC)   mepc_q   <= new_val & ~DW'(3);
        if (wr && csr_addr_i == A_MCAUSE) mcause_q <= new_val;
        if (wr && csr_addr_i == A_MSTATUS) begin
          mstatus_mie_q  <= new_val[3];
          mstatus_mpie_q <= new_val[7];
        end
        if (mret_i) begin
          mstatus_mie_q  <= mstatus_mpie_q;
          mstatus_mpie_q <= 1'b1;
        end
      end
      mcycle_q  <= (wr && csr_addr_i == A_MCYCLE)  ? new_val : mcycle_q + DW'(1);
      mcycleh_q <= (wr && csr_addr_i == A_MCYCLEH) ? new_val : mcycleh_q + DW'(&mcycle_q);
    end
  end

  assign base      = {mtvec_q[DW-1:2], 2'b00};
  assign trap_pc_o = mtvec_q[0] ? base + DW'({cause_q, 2'b00}) : base;
  assign irq_req_o = (state_q == PEND);
  assign mret_pc_o = mepc_q;

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed bench for csr_irq_unit: CSR expectations queue up as stimulus is applied and are checked by reading back.
module tb_csr_irq_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] csr_addr_i = '0;
  logic [1:0]  csr_op_i = '0;
  logic [31:0] csr_wdata_i = '0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        t_intr_i = 1'b0, e_intr_i = 1'b0, sw_intr_i = 1'b0;
  logic [3:0]  lirq_i = '0;
  logic [31:0] pc_i = '0;
  logic        irq_req_o;
  logic        trap_ack_i = 1'b0;
  logic [31:0] trap_pc_o;
  logic        mret_i = 1'b0;
  logic [31:0] mret_pc_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [11:0] addr;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  csr_irq_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
    .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .t_intr_i(t_intr_i), .e_intr_i(e_intr_i), .sw_intr_i(sw_intr_i), .lirq_i(lirq_i),
    .pc_i(pc_i), .irq_req_o(irq_req_o), .trap_ack_i(trap_ack_i), .trap_pc_o(trap_pc_o),
    .mret_i(mret_i), .mret_pc_o(mret_pc_o)
  );

  always #10 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One CSR operation committed at the next posedge; rd is the pre-update read value.
  task automatic csr_op(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                        output logic [31:0] rd);
    @(negedge clk_i);
    csr_addr_i = a; csr_op_i = op; csr_wdata_i = wd;
    #1 rd = csr_rdata_o;
    @(posedge clk_i);
    #1 csr_op_i = 2'b00; csr_addr_i = '0;
  endtask

  task automatic expect_csr(input string tag, input logic [11:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.addr = a; e.exp = v;
    sb.push_back(e);
  endtask

  // Reads are taken with a zero-operand set that is withdrawn before the next edge.
  task automatic drain();
    exp_t e;
    logic [31:0] rd;
    @(negedge clk_i);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      csr_addr_i = e.addr; csr_op_i = 2'b10; csr_wdata_i = '0;
      #1 rd = csr_rdata_o;
      csr_op_i = 2'b00;
      chk(e.tag, rd, e.exp);
    end
  endtask

  initial begin
    logic [31:0] rd;

    // Reset state
    #2 csr_addr_i = 12'h7C0; csr_op_i = 2'b01;
    #1 chk("rst_illegal", {31'b0, csr_illegal_o}, 32'h0);
    csr_addr_i = 12'h300;
    #1 chk("rst_rdata", csr_rdata_o, 32'h0);
    csr_op_i = 2'b00;
    chk("rst_irq", {31'b0, irq_req_o}, 32'h0);
    chk("rst_trap_pc", trap_pc_o, 32'h0);
    chk("rst_mret_pc", mret_pc_o, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Direct-mode timer interrupt
    csr_op(12'h305, 2'b01, 32'h100, rd);
    csr_op(12'h304, 2'b01, 32'h80, rd);
    csr_op(12'h300, 2'b01, 32'h8, rd);
    expect_csr("a_mtvec", 12'h305, 32'h100);
    expect_csr("a_mie", 12'h304, 32'h80);
    expect_csr("a_mstatus", 12'h300, 32'h8);
    drain();
    @(negedge clk_i) t_intr_i = 1'b1;
    @(posedge clk_i) #1 chk("a_irq_1cyc", {31'b0, irq_req_o}, 32'h0);
    @(posedge clk_i) #1 chk("a_irq_2cyc", {31'b0, irq_req_o}, 32'h1);
    chk("a_trap_pc", trap_pc_o, 32'h100);
    @(negedge clk_i) t_intr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 chk("a_irq_held", {31'b0, irq_req_o}, 32'h1);
    chk("a_trap_pc_held", trap_pc_o, 32'h100);
    @(negedge clk_i);
    trap_ack_i = 1'b1; pc_i = 32'h2E;
    csr_addr_i = 12'h341; csr_op_i = 2'b01; csr_wdata_i = 32'h12345678;
    @(posedge clk_i) #1 trap_ack_i = 1'b0; csr_op_i = 2'b00;
    chk("a_irq_acked", {31'b0, irq_req_o}, 32'h0);
    expect_csr("a_mepc", 12'h341, 32'h2C);
    expect_csr("a_mcause", 12'h342, 32'h80000007);
    expect_csr("a_mstatus_trap", 12'h300, 32'h80);
    expect_csr("a_mip", 12'h344, 32'h0);
    drain();
    chk("a_mret_pc", mret_pc_o, 32'h2C);
    @(negedge clk_i) mret_i = 1'b1;
    @(posedge clk_i) #1 mret_i = 1'b0;
    expect_csr("a_mstatus_mret", 12'h300, 32'h88);
    drain();
    chk("a_mret_pc2", mret_pc_o, 32'h2C);
    chk("a_irq_after_mret", {31'b0, irq_req_o}, 32'h0);

    // Vectored mode, MEI beats MTI, pending survives disables
    csr_op(12'h305, 2'b01, 32'h203, rd);
    csr_op(12'h304, 2'b01, 32'h880, rd);
    expect_csr("b_mtvec", 12'h305, 32'h201);
    expect_csr("b_mie", 12'h304, 32'h880);
    drain();
    @(negedge clk_i) begin e_intr_i = 1'b1; t_intr_i = 1'b1; end
    repeat (2) @(posedge clk_i);
    #1 chk("b_irq", {31'b0, irq_req_o}, 32'h1);
    chk("b_trap_pc", trap_pc_o, 32'h22C);
    @(negedge clk_i) begin e_intr_i = 1'b0; t_intr_i = 1'b0; end
    csr_op(12'h304, 2'b01, 32'h0, rd);
    csr_op(12'h300, 2'b11, 32'h8, rd);
    #1 chk("b_irq_committed", {31'b0, irq_req_o}, 32'h1);
    chk("b_trap_pc_held", trap_pc_o, 32'h22C);
    @(negedge clk_i) begin trap_ack_i = 1'b1; pc_i = 32'h400; end
    @(posedge clk_i) #1 trap_ack_i = 1'b0;
    expect_csr("b_mepc", 12'h341, 32'h400);
    expect_csr("b_mcause", 12'h342, 32'h8000000B);
    expect_csr("b_mstatus", 12'h300, 32'h0);
    drain();

    // Local lines: lowest index wins; then reset while pending
    csr_op(12'h304, 2'b01, 32'h000C0000, rd);
    csr_op(12'h300, 2'b01, 32'h8, rd);
    @(negedge clk_i) lirq_i = 4'b1100;
    repeat (2) @(posedge clk_i);
    #1 chk("c_irq", {31'b0, irq_req_o}, 32'h1);
    chk("c_trap_pc", trap_pc_o, 32'h248);
    @(negedge clk_i) #3 rst_ni = 1'b0;
    #1 chk("c_rst_irq", {31'b0, irq_req_o}, 32'h0);
    chk("c_rst_mret_pc", mret_pc_o, 32'h0);
    chk("c_rst_trap_pc", trap_pc_o, 32'h0);
    lirq_i = '0;
    @(negedge clk_i) rst_ni = 1'b1;
    expect_csr("c_mepc", 12'h341, 32'h0);
    expect_csr("c_mcause", 12'h342, 32'h0);
    expect_csr("c_mtvec", 12'h305, 32'h0);
    drain();

    // CSR access semantics
    csr_op(12'h300, 2'b01, 32'hFFFFFFFF, rd);
    expect_csr("d_mstatus_bits", 12'h300, 32'h88);
    drain();
    csr_op(12'h300, 2'b01, 32'h8, rd);
    csr_op(12'h300, 2'b11, 32'h8, rd);
    chk("d_clear_pre", rd, 32'h8);
    csr_op(12'h340, 2'b01, 32'hDEADBEEF, rd);
    csr_op(12'h304, 2'b01, 32'hFFFFFFFF, rd);
    expect_csr("d_mstatus_cleared", 12'h300, 32'h0);
    expect_csr("d_mscratch", 12'h340, 32'hDEADBEEF);
    expect_csr("d_mie_mask", 12'h304, 32'h000F0888);
    drain();
    @(negedge clk_i) csr_addr_i = 12'h340;
    #1 chk("d_rdata_noop", csr_rdata_o, 32'h0);
    @(negedge clk_i) begin lirq_i = 4'b0001; sw_intr_i = 1'b1; end
    csr_op(12'h344, 2'b01, 32'hFFFFFFFF, rd);
    expect_csr("d_mip_ro", 12'h344, 32'h00010008);
    drain();
    csr_addr_i = 12'h7C0; csr_op_i = 2'b01; csr_wdata_i = 32'h5;
    #1 chk("d_illegal", {31'b0, csr_illegal_o}, 32'h1);
    chk("d_illegal_rdata", csr_rdata_o, 32'h0);
    csr_op_i = 2'b00;
    #1 chk("d_illegal_noop", {31'b0, csr_illegal_o}, 32'h0);
    lirq_i = '0; sw_intr_i = 1'b0;

    // 64-bit cycle counter carry
    csr_op(12'hB80, 2'b01, 32'h0, rd);
    csr_op(12'hB00, 2'b01, 32'hFFFFFFFF, rd);
    expect_csr("e_mcycle_wr", 12'hB00, 32'hFFFFFFFF);
    expect_csr("e_mcycleh_wr", 12'hB80, 32'h0);
    drain();
    expect_csr("e_mcycle_wrap", 12'hB00, 32'h0);
    expect_csr("e_mcycleh_carry", 12'hB80, 32'h1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_irq_unit.md
CSR_IRQ_UNIT -- requirements
Module: csr_irq_unit

Interface
REQ-001 SHALL have parameter DW, default 32, data width; only 32 is legal.
REQ-002 SHALL have parameter ADDRW, default 12, CSR address width.
REQ-003 SHALL have parameter NLIRQ, default 4, local interrupt lines, legal range 1..16.
REQ-004 SHALL have clk_i  input  1  clock; all state updates on posedge clk_i.
REQ-005 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have csr_addr_i  input  ADDRW  CSR address.
REQ-007 SHALL have csr_op_i  input  2  operation: 00 none, 01 write, 10 set, 11 clear.
REQ-008 SHALL have csr_wdata_i  input  DW  operand for write/set/clear.
REQ-009 SHALL have csr_rdata_o  output  DW  current (pre-update) value of the addressed CSR.
REQ-010 SHALL have csr_illegal_o  output  1  addressed CSR does not exist while csr_op_i != 00.
REQ-011 SHALL have t_intr_i, e_intr_i, sw_intr_i  input  1 each  timer, external, software interrupt levels.
REQ-012 SHALL have lirq_i  input  NLIRQ  local interrupt levels.
REQ-013 SHALL have pc_i  input  DW  PC of the instruction to be interrupted.
REQ-014 SHALL have irq_req_o  output  1  trap request to the core.
REQ-015 SHALL have trap_ack_i  input  1  core accepts trap this cycle.
REQ-016 SHALL have trap_pc_o  output  DW  handler address, valid while irq_req_o=1.
REQ-017 SHALL have mret_i  input  1  core executes MRET this cycle.
REQ-018 SHALL have mret_pc_o  output  DW  return address, always equal to mepc.

Function
REQ-019 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80.
REQ-020 SHALL return csr_rdata_o combinationally; 0 when csr_op_i=00 or address illegal.
REQ-021 SHALL update the addressed CSR at the next edge: write = wdata, set = old|wdata, clear = old&~wdata; illegal address -> no update.
REQ-022 SHALL treat mip as read-only (writes legal, ignored); mie/mip implement only bits 3, 7, 11 and 16..16+NLIRQ-1, other bits read 0.
REQ-023 SHALL register interrupt inputs once per cycle into mip: MSIP bit3, MTIP bit7, MEIP bit11, lirq_i[k] bit 16+k; mip follows input levels with 1-cycle latency.
REQ-024 SHALL force mepc[1:0]=0 and mtvec[1]=0 on write; mtvec[0]=1 selects vectored mode.
REQ-025 SHALL increment the 64-bit {mcycleh,mcycle} every cycle with carry into mcycleh; a CSR write to either half replaces increment for that half that cycle; 0xFFFFFFFF_FFFFFFFF wraps to 0.
REQ-026 SHALL have FSM states RUN and PEND; reset state RUN.
REQ-027 SHALL go RUN->PEND when mstatus.MIE=1, (mip & mie)!=0 and mret_i=0, latching the cause of highest priority: MEI(11) > MSI(3) > MTI(7) > lirq lowest index first (16+k).
REQ-028 SHALL assert irq_req_o exactly while in PEND; latched cause stays stable even if the source deasserts.
REQ-029 SHALL drive trap_pc_o = mtvec base (bits[DW-1:2]<<2) in direct mode, base + 4*cause in vectored mode.
REQ-030 SHALL on trap_ack_i in PEND: mepc<=pc_i&~3, mcause<={1'b1,cause}, MPIE<=MIE, MIE<=0, go to RUN; trap_ack_i in RUN ignored.
REQ-031 SHALL on mret_i: MIE<=MPIE, MPIE<=1; FSM state unchanged.
REQ-032 SHALL give trap_ack_i priority over a same-cycle CSR write to mstatus/mepc/mcause (write dropped); other CSRs still written.
REQ-033 SHALL give trap_ack_i priority over a same-cycle mret_i (mret_i ignored).
REQ-034 SHALL remain in PEND if software clears mstatus.MIE or mie while PEND (request, once raised, is committed).

Reset
REQ-035 SHALL, when rst_ni=0 asynchronously, clear all CSRs, mip sample registers and latched cause to 0, set FSM to RUN; irq_req_o=0, trap_pc_o=0, mret_pc_o=0, csr_rdata_o=0, csr_illegal_o=0 in reset; reset mid-PEND drops the request without updating mepc/mcause.

Verification
REQ-036 SHALL cover: mtvec=0x100 direct, mie[7]=1, MIE=1, t_intr_i=1 -> irq_req_o=1 two cycles later, trap_pc_o=0x100; ack with pc_i=0x2C -> mepc=0x2C, mcause=0x80000007, MIE=0, MPIE=1.
REQ-037 SHALL cover: mtvec=0x201 vectored, mie bits 11,7 set, e_intr_i and t_intr_i same cycle -> cause 11, trap_pc_o=0x22C.
REQ-038 SHALL cover: mstatus=0x8, clear op wdata=0x8 -> csr_rdata_o=0x8, next read 0x0; write to mip 0xFFFFFFFF -> mip unchanged; address 0x7C0 -> csr_illegal_o=1.
REQ-039 SHALL cover: mcycle write 0xFFFFFFFF, mcycleh=0 -> next cycle mcycle=0, mcycleh=1.
REQ-040 SHALL cover: mret_i after trap -> MIE=1, MPIE=1, mret_pc_o=mepc; rst_ni pulsed low while PEND -> irq_req_o=0 immediately, mepc=0.
